// File: rtl/top_varint_decode.sv
// Fetches one protobuf varint from DRAM over an 8-lane byte interface and returns the value
// adjusted for its protobuf field type.
module top_varint_decode #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned MAX_BYTES = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [ADDR_W-1:0]      src_addr,
  input  logic [4:0]             field_type,
  output logic [7:0]             dram_en,
  output logic [7:0][ADDR_W-1:0] dram_addr,
  output logic                   dram_rdwr,
  input  logic [7:0][7:0]        dram_data,
  input  logic [7:0]             dram_valid,
  output logic [63:0]            value,
  output logic [3:0]             bytes_read,
  output logic                   done,
  output logic                   error
);

  localparam int NumBytes = 10;

  typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StDone} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          base_q, base_d;
  logic [4:0]                 ftype_q, ftype_d;
  logic [7:0]                 cap_q, cap_d;
  logic [NumBytes-1:0][7:0]   data_q, data_d;
  logic [3:0]                 len_q, len_d;
  logic                       err_q, err_d;
  logic [63:0]                raw_q, raw_d;
  logic                       raw_vld_q, raw_vld_d;
  logic [63:0]                value_q, value_d;
  logic [3:0]                 bytes_q, bytes_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic                       cap_all, hit_lo, hit_hi;
  logic [3:0]                 len_lo, len_hi;

  function automatic logic [63:0] assemble(input logic [NumBytes-1:0][7:0] b,
                                           input logic [3:0] n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NumBytes; k++) begin
      if (k < int'(n)) r = r | (64'(b[k][6:0]) << (7 * k));
    end
    return r;
  endfunction

  function automatic logic [63:0] map_type(input logic [4:0] ft, input logic [63:0] raw);
    logic [31:0] zz32;
    logic [63:0] m;
    zz32 = {1'b0, raw[31:1]} ^ {32{raw[0]}};
    case (ft)
      5'd5, 5'd14: m = {{32{raw[31]}}, raw[31:0]};
      5'd13:       m = {32'b0, raw[31:0]};
      5'd8:        m = {63'b0, |raw};
      5'd17:       m = {{32{zz32[31]}}, zz32};
      5'd18:       m = {1'b0, raw[63:1]} ^ {64{raw[0]}};
      default:     m = raw;
    endcase
    return m;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Lane capture: each lane is taken once, whenever its valid shows up
  always_comb begin
    cap_d  = cap_q;
    data_d = data_q;
    case (state_q)
      StReq1, StReq2: cap_d = '0;
      StWait1: begin
        for (int i = 0; i < 8; i++) begin
          if (dram_valid[i] && !cap_q[i]) begin
            data_d[i] = dram_data[i];
            cap_d[i]  = 1'b1;
          end
        end
      end
      StWait2: begin
        for (int i = 0; i < 2; i++) begin
          if (dram_valid[i] && !cap_q[i]) begin
            data_d[8+i] = dram_data[i];
            cap_d[i]    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign cap_all = (state_q == StWait1) ? (&cap_d) : (&cap_d[1:0]);

  // Terminator scan; descending loops leave the lowest hit in place
  always_comb begin
    hit_lo = 1'b0;
    len_lo = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      if (!data_d[k][7]) begin
        hit_lo = 1'b1;
        len_lo = 4'(k + 1);
      end
    end
    hit_hi = 1'b0;
    len_hi = 4'(NumBytes);
    for (int k = NumBytes - 1; k >= 8; k--) begin
      if (k < int'(MAX_BYTES) && !data_d[k][7]) begin
        hit_hi = 1'b1;
        len_hi = 4'(k + 1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en) state_d = StReq1;
      StReq1:  state_d = StWait1;
      StWait1: if (cap_all) state_d = hit_lo ? StDone : StReq2;
      StReq2:  state_d = StWait2;
      StWait2: if (cap_all) state_d = StDone;
      StDone:  if (done_q && !en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath; DONE assembles raw first, then applies the type mapping
  always_comb begin
    base_d    = base_q;
    ftype_d   = ftype_q;
    len_d     = len_q;
    err_d     = err_q;
    raw_d     = raw_q;
    raw_vld_d = raw_vld_q;
    value_d   = value_q;
    bytes_d   = bytes_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      StIdle: begin
        if (en) begin
          base_d    = src_addr;
          ftype_d   = field_type;
          raw_vld_d = 1'b0;
        end
      end
      StWait1: begin
        if (cap_all && hit_lo) begin
          len_d = len_lo;
          err_d = 1'b0;
        end
      end
      StWait2: begin
        if (cap_all) begin
          len_d = len_hi;
          err_d = !hit_hi;
        end
      end
      StDone: begin
        if (!raw_vld_q) begin
          raw_d     = err_q ? '0 : assemble(data_q, len_q);
          raw_vld_d = 1'b1;
        end else if (!done_q) begin
          value_d = err_q ? '0 : map_type(ftype_q, raw_q);
          bytes_d = len_q;
          error_d = err_q;
          done_d  = 1'b1;
        end else if (!en) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          raw_vld_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      ftype_q   <= '0;
      cap_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      raw_q     <= '0;
      raw_vld_q <= 1'b0;
      value_q   <= '0;
      bytes_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      base_q    <= base_d;
      ftype_q   <= ftype_d;
      cap_q     <= cap_d;
      data_q    <= data_d;
      len_q     <= len_d;
      err_q     <= err_d;
      raw_q     <= raw_d;
      raw_vld_q <= raw_vld_d;
      value_q   <= value_d;
      bytes_q   <= bytes_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Output logic: read bursts are decoded straight from the state
  always_comb begin
    dram_en   = '0;
    dram_addr = '0;
    case (state_q)
      StReq1: begin
        dram_en = 8'hFF;
        for (int i = 0; i < 8; i++) dram_addr[i] = base_q + ADDR_W'(i);
      end
      StReq2: begin
        dram_en      = 8'h03;
        dram_addr[0] = base_q + ADDR_W'(8);
        dram_addr[1] = base_q + ADDR_W'(9);
      end
      default: ;
    endcase
  end

  assign dram_rdwr  = 1'b0;
  assign value      = value_q;
  assign bytes_read = bytes_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
